// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan path.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;

  typedef logic [1:0] idx_t;

  function automatic logic [3:0] an_sel(idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display data in, scanned segment/anode drive out.
// master = digit source, slave = scan driver.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output digits_in, dp_in, blank_lz, brightness,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, blank_lz, brightness,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/seven_seg_decoder.sv
// BCD nibble to active-low segment glyph.
// Non-BCD codes render as a dark digit.
module seven_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with
// frame shadowing, zero blanking, dead time and PWM dimming.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 4
) (
  input  logic clk,
  input  logic rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] TC   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD = PW'(DEAD_CYC);

  logic [PW-1:0] presc;
  idx_t          idx;
  logic [3:0]    pwm_cnt;
  logic [15:0]   sh_dig;
  logic [3:0]    sh_dp;
  logic          sh_blz;

  logic          tc;
  logic          load;
  logic          dead;
  logic          blank;
  logic          lit;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign tc   = presc == TC;
  assign load = tc && (idx == 2'd3);
  assign dead = presc < DEAD;
  assign nib  = sh_dig[{idx, 2'b00} +: 4];
  assign lit  = !dead && !blank && (pwm_cnt <= bus.brightness);

  seven_seg_decoder u_dec (
    .bcd (nib),
    .seg (glyph)
  );

  // a digit is leading only if every digit above it is zero too
  always_comb begin
    blank = 1'b0;
    if (sh_blz) begin
      case (idx)
        2'd3:    blank = sh_dig[15:12] == 4'h0;
        2'd2:    blank = sh_dig[15:8] == 8'h0;
        2'd1:    blank = sh_dig[15:4] == 12'h0;
        default: blank = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc          <= '0;
      idx            <= '0;
      pwm_cnt        <= '0;
      sh_dig         <= '0;
      sh_dp          <= '0;
      sh_blz         <= 1'b0;
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.an         <= AN_OFF;
      bus.frame_tick <= 1'b0;
    end else begin
      presc   <= tc ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (tc) begin
        idx <= idx + 1'b1;
      end
      bus.frame_tick <= load;
      if (load) begin
        sh_dig <= bus.digits_in;
        sh_dp  <= bus.dp_in;
        sh_blz <= bus.blank_lz;
      end
      bus.an <= lit ? an_sel(idx) : AN_OFF;
      if (dead || blank) begin
        bus.seg <= SEG_OFF;
        bus.dp  <= 1'b1;
      end else begin
        bus.seg <= glyph;
        bus.dp  <= ~sh_dp[idx];
      end
    end
  end

endmodule
